// File: rtl/shift_sched_pkg.sv
// Shared FSM state type and rotate-direction encodings for the shift scheduler.
package shift_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_core.sv
// Combinational WIDTH-bit circular rotate by a variable amount in either direction.
module shift_core
  import shift_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] data_o
);

  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] shr;
  logic [2*WIDTH-1:0] shl;

  // Shifting a doubled copy makes the bits falling off one end reappear at the other.
  always_comb begin
    dbl = {data_i, data_i};
    shr = dbl >> amt_i;
    shl = dbl << amt_i;
    if (dir_i == DIR_LEFT) begin
      data_o = shl[2*WIDTH-1:WIDTH];
    end else begin
      data_o = shr[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Two-requester round-robin scheduler running one-bit-per-cycle rotate jobs.
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [AMT_W-1:0] amt0,
  input  logic [AMT_W-1:0] amt1,
  input  logic             dir0,
  input  logic             dir1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               id_q, id_d;
  logic               prio_q, prio_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   step;

  shift_core #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_core (
    .data_i (work_q),
    .amt_i  (AMT_W'(1)),
    .dir_i  (dir_q),
    .data_o (step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    id_d    = id_q;
    prio_d  = prio_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          work_d = gnt1 ? a1 : a0;
          cnt_d  = gnt1 ? amt1 : amt0;
          dir_d  = gnt1 ? dir1 : dir0;
          id_d   = gnt1;
          prio_d = gnt0;
          if (cnt_d == '0) begin
            state_d = DONE;
            y_d     = work_d;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        work_d = step;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
          y_d     = step;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants and done pulses are masked by reset so an aborted cycle shows no handshake.
  always_comb begin
    gnt0  = (state_q == IDLE) && !reset && req0 && (!req1 || !prio_q);
    gnt1  = (state_q == IDLE) && !reset && req1 && (!req0 || prio_q);
    done0 = (state_q == DONE) && !reset && !id_q;
    done1 = (state_q == DONE) && !reset && id_q;
    busy  = (state_q != IDLE);
    y     = y_q;
  end

endmodule

// File: tb/tb_shift_sched.sv
// Directed and randomized checks of shift_sched against a transaction-level reference.
module tb_shift_sched;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [W-1:0]  a0, a1;
  logic [AW-1:0] amt0, amt1;
  logic          dir0, dir1;
  logic          gnt0, gnt1, done0, done1, busy;
  logic [W-1:0]  y;

  shift_sched #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .a0(a0), .a1(a1),
    .amt0(amt0), .amt1(amt1), .dir0(dir0), .dir1(dir1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one job record plus round-robin pointer (1 = favour requester 1).
  int        cyc = 0;
  bit        job_act = 0;
  int        job_grant, job_done;
  bit        job_id;
  logic [W-1:0] job_res;
  logic [W-1:0] m_y = '0;
  bit        m_ptr = 0;

  bit        last_g0, last_g1, last_d0, last_d1;
  logic [W-1:0] last_y;

  function automatic logic [W-1:0] rot(input logic [W-1:0] v, input int n, input logic left);
    int unsigned x;
    int r;
    r = left ? (W - n) % W : n;
    x = v;
    x = (x >> r) | (x << (W - r));
    return x[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Evaluate one clock cycle: inputs are already driven, compare at negedge, advance model.
  task automatic cycle();
    bit eg0, eg1, ed0, ed1, eb;
    int amt;
    @(negedge clk);
    eg0 = 0; eg1 = 0;
    if (!reset && !job_act) begin
      if (req0 && (!req1 || !m_ptr)) eg0 = 1;
      else if (req1)                  eg1 = 1;
    end
    if (job_act && cyc == job_done) m_y = job_res;
    eb  = job_act && (cyc > job_grant);
    ed0 = !reset && job_act && (cyc == job_done) && !job_id;
    ed1 = !reset && job_act && (cyc == job_done) && job_id;
    check("gnt0", 32'(gnt0), 32'(eg0));
    check("gnt1", 32'(gnt1), 32'(eg1));
    check("done0", 32'(done0), 32'(ed0));
    check("done1", 32'(done1), 32'(ed1));
    check("busy", 32'(busy), 32'(eb));
    check("y", 32'(y), 32'(m_y));
    last_g0 = gnt0; last_g1 = gnt1; last_d0 = done0; last_d1 = done1; last_y = y;
    if (reset) begin
      job_act = 0; m_y = '0; m_ptr = 0;
    end else if (eg0 || eg1) begin
      amt       = eg1 ? int'(amt1) : int'(amt0);
      job_act   = 1;
      job_grant = cyc;
      job_done  = cyc + 1 + amt;
      job_id    = eg1;
      job_res   = eg1 ? rot(a1, amt, dir1) : rot(a0, amt, dir0);
      m_ptr     = eg0;
    end else if (job_act && cyc == job_done) begin
      job_act = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one request and measure grant-to-done latency and the result shown at done.
  task automatic do_job(input string tag, input bit id, input logic [W-1:0] a,
                        input logic [AW-1:0] amt, input logic dir,
                        input int exp_lat, input logic [W-1:0] exp_y);
    int gc = -1, dc = -1;
    logic [W-1:0] yd = 'x;
    if (id) begin req1 = 1; a1 = a; amt1 = amt; dir1 = dir; end
    else    begin req0 = 1; a0 = a; amt0 = amt; dir0 = dir; end
    for (int i = 0; i < 30 && dc < 0; i++) begin
      cycle();
      if (id ? last_g1 : last_g0) begin
        gc = cyc - 1;
        if (id) begin req1 = 0; a1 = ~a; end
        else    begin req0 = 0; a0 = ~a; end
      end
      if (id ? last_d1 : last_d0) begin dc = cyc - 1; yd = last_y; end
    end
    check({tag, "_lat"}, 32'(dc - gc), 32'(exp_lat));
    check({tag, "_y"}, 32'(yd), 32'(exp_y));
    cycle();
  endtask

  initial begin
    int gids[$];
    int gcyc[$];
    logic [W-1:0] dys[$];
    int d0c;
    reset = 1; req0 = 0; req1 = 0; a0 = '0; a1 = '0;
    amt0 = '0; amt1 = '0; dir0 = 0; dir1 = 0;
    @(posedge clk); #1;
    cycle();
    reset = 0;
    cycle();

    do_job("req032", 0, 8'b11010111, 3'd3, 1'b0, 4, 8'b11111010);
    do_job("req033", 1, 8'b11110011, 3'd1, 1'b1, 2, 8'b11100111);
    do_job("req034", 0, 8'b00000001, 3'd0, 1'b0, 1, 8'b00000001);

    // Both requesters held high from reset.
    reset = 1; req0 = 1; req1 = 1;
    a0 = 8'b00000001; amt0 = 3'd7; dir0 = 1;
    a1 = 8'b00000001; amt1 = 3'd4; dir1 = 0;
    cycle();
    reset = 0;
    d0c = -1;
    for (int i = 0; i < 40 && gids.size() < 3; i++) begin
      cycle();
      if (last_g0) begin gids.push_back(0); gcyc.push_back(cyc - 1); end
      if (last_g1) begin gids.push_back(1); gcyc.push_back(cyc - 1); end
      if (last_d0 && d0c < 0) d0c = cyc - 1;
      if (last_d0 || last_d1) dys.push_back(last_y);
    end
    check("req035_n", 32'(gids.size()), 32'd3);
    if (gids.size() == 3 && dys.size() >= 2) begin
      check("req035_first", 32'(gids[0]), 32'd0);
      check("req035_second", 32'(gids[1]), 32'd1);
      check("req035_third", 32'(gids[2]), 32'd0);
      check("req035_y0", 32'(dys[0]), 32'h80);
      check("req035_y1", 32'(dys[1]), 32'h10);
      check("req035_gap", 32'(gcyc[1] - d0c), 32'd1);
    end
    req0 = 0; req1 = 0;
    for (int i = 0; i < 12; i++) cycle();

    // Reset during the second RUN cycle of an amt=5 job.
    req0 = 1; a0 = 8'hA5; amt0 = 3'd5; dir0 = 0;
    for (int i = 0; i < 5 && !last_g0; i++) cycle();
    check("req036_gnt", 32'(last_g0), 32'd1);
    cycle();
    reset = 1; req0 = 1; a0 = 8'h3C; amt0 = 3'd2; dir0 = 1;
    cycle();
    reset = 0;
    cycle();
    check("req036_y", 32'(last_y), 32'd0);
    check("req036_regrant", 32'(last_g0), 32'd1);
    req0 = 0;
    for (int i = 0; i < 6; i++) cycle();

    // Randomized traffic with occasional resets and operands changing every cycle.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(79) == 0);
      a0 = W'($urandom); a1 = W'($urandom);
      amt0 = AW'($urandom); amt1 = AW'($urandom);
      dir0 = 1'($urandom); dir1 = 1'($urandom);
      if (!req0 && $urandom_range(2) == 0) req0 = 1;
      if (!req1 && $urandom_range(2) == 0) req1 = 1;
      cycle();
      if (last_g0 && $urandom_range(1) == 0) req0 = 0;
      if (last_g1 && $urandom_range(1) == 0) req1 = 0;
    end
    reset = 0; req0 = 0; req1 = 0;
    for (int i = 0; i < 12; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 Parameter WIDTH, default 8, data width of operands and result.
REQ-002 Parameter AMT_W, default 3, shift-amount width; SHALL equal clog2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  shift request from requester 0 and requester 1; held high until granted.
REQ-006 a0, a1  input  WIDTH each  operand of requester 0 and requester 1.
REQ-007 amt0, amt1  input  AMT_W each  rotate amount of requester 0 and requester 1.
REQ-008 dir0, dir1  input  1 each  direction of requester 0 and requester 1; 0 = rotate right, 1 = rotate left.
REQ-009 gnt0, gnt1  output  1 each  one-cycle grant; operands sampled in this cycle.
REQ-010 done0, done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-011 y  output  WIDTH  result of the last completed job; held until next completion.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Operation SHALL be a circular rotate: bits leaving one end re-enter at the other; no zero fill.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 In IDLE, gnt SHALL be combinational from req: at most one of gnt0/gnt1 high; no grant in RUN or DONE.
REQ-016 Arbitration SHALL be round-robin:
- One request pending: grant it.
- Both pending: grant the requester not granted most recently.
- Priority pointer SHALL update only on a grant.
REQ-017 On the grant edge, the block SHALL latch the operand, amount and direction of the granted requester, and record the requester id.
REQ-018 On the grant edge, the next state SHALL be RUN if amt != 0, else DONE.
REQ-019 In RUN, each edge SHALL rotate the working register by exactly 1 position in the latched direction and decrement the counter.
REQ-020 RUN SHALL exit to DONE on the edge where the counter reaches 0.
REQ-021 In DONE, for exactly one cycle:
- done of the recorded requester SHALL be high.
- y SHALL show the result.
- The next state SHALL be IDLE.
REQ-022 Latency: grant in cycle T, done in cycle T+1+amt, for every amt including 0.
REQ-023 y SHALL update on the edge entering DONE and otherwise hold.
REQ-024 Operand input changes after the grant cycle SHALL NOT affect the running job.
REQ-025 A requester still asserting req in the cycle after DONE SHALL be eligible for a grant in that IDLE cycle; the next grant is therefore at T+2+amt at the earliest.
REQ-026 done0 and done1 SHALL never be high together; gnt and done SHALL never be high in the same cycle.

Reset
REQ-027 reset SHALL take priority over all other activity, including in mid-RUN and in DONE; the aborted job SHALL produce no done pulse.
REQ-028 After reset:
- state = IDLE, y = 0, busy = 0.
- gnt0, gnt1, done0, done1 = 0.
- Counter = 0.
- Priority pointer favours requester 0 on the first simultaneous request.

Structure
REQ-029 A shared package shift_sched_pkg SHALL hold the FSM state enumeration and the constants DIR_RIGHT = 0 and DIR_LEFT = 1.
REQ-030 A single sub-module, shift_core, SHALL implement the combinational WIDTH-bit rotate (inputs: data, amount, direction). shift_sched SHALL instantiate it with amount fixed at 1 for the per-cycle step.
REQ-031 No other sub-modules; arbitration, FSM and counter SHALL reside in shift_sched.

Verification
REQ-032 Reset, then req0 with a0=11010111, amt0=3, dir0=0:
- gnt0 in cycle T.
- done0 in cycle T+4.
- y=11111010.
REQ-033 req1 with a1=11110011, amt1=1, dir1=1:
- done1 in cycle T+2.
- y=11100111.
REQ-034 amt=0 edge case: req0 with a0=00000001, amt0=0:
- done0 in cycle T+1.
- y=00000001.
REQ-035 Simultaneous req0 and req1 held high from reset, a0=00000001 amt0=7 dir0=1, a1=00000001 amt1=4 dir1=0:
- Requester 0 granted first; y=10000000 at its done.
- Requester 1 granted in the IDLE cycle after that DONE; y=00010000.
- Third grant goes back to requester 0.
REQ-036 Assert reset during the second RUN cycle of an amt=5 job:
- No done pulse.
- y=0, busy=0 on the next cycle.
- A new request is granted in the first cycle after reset deasserts.
